fft_frame_capture: RTL and testbench
====================================

Name: fft_frame_capture

Overview:
- Sits on the output side of the FFT interface: consumes the bin stream (real/imag, bin address, read_valid) that the FFT produces, and stores one complete 512-bin frame.
- While storing, computes the peak-magnitude bin for the pitch-detection logic.
- Holds the frame for a downstream reader behind a ready/ack handshake, then re-arms for the next frame.

Parameters:
- LOG_DEPTH, 9, log2 of bins per frame (N = 512).
- DW, 18, bit width of each real/imag component.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_real_in  in  DW  FFT bin real part, signed two's complement.
- data_imag_in  in  DW  FFT bin imaginary part, signed.
- bin_addr_in  in  LOG_DEPTH  bin index of the current sample.
- read_valid  in  1  bin inputs valid this cycle.
- rd_addr  in  LOG_DEPTH  readback address.
- rd_en  in  1  readback request.
- rd_data  out  2*DW  {imag, real} at rd_addr.
- rd_valid  out  1  rd_data valid.
- frame_ready  out  1  complete frame held.
- frame_ack  in  1  reader done; release buffer.
- peak_bin  out  LOG_DEPTH  bin index of maximum magnitude.
- peak_mag  out  DW+1  magnitude of peak_bin.
- peak_valid  out  1  one-cycle pulse when peak_bin/peak_mag update.
- seq_error  out  1  sticky; bin address out of sequence.
- overrun_cnt  out  8  saturating count of bins dropped while holding.

Behaviour:
- Reset (reset==0, asynchronous): state IDLE; all outputs 0. Buffer RAM contents are not cleared.
- Magnitude approximation: mag = |re| + |im|.
  - |x| saturates: -2^(DW-1) maps to 2^(DW-1)-1.
  - Sum is DW+1 bits unsigned; no overflow is possible.
- State IDLE:
  - read_valid with bin_addr_in==0: write bin 0, set expected address to 1, reset running max, go to CAPTURE.
  - Any other valid bin is ignored (mid-frame start).
- State CAPTURE:
  - Each read_valid with bin_addr_in==expected: write {imag,real} to RAM[addr], increment expected.
  - Peak tracking covers only bins 1..N/2-1 (DC and mirror half excluded). Update when mag > running max (strict), so the lowest bin wins ties.
  - read_valid with bin_addr_in!=expected: set seq_error, discard the partial frame, go to IDLE. An address-0 sample in that same cycle is not restarted.
  - Gaps (read_valid low) are allowed with no timeout.
  - Bin N-1 written: next cycle go to HOLD, frame_ready=1, peak_bin/peak_mag loaded, peak_valid=1 for exactly one cycle.
  - If all half-spectrum magnitudes are 0: peak_bin=1, peak_mag=0.
- State HOLD:
  - Capture disabled.
  - Each read_valid arriving while frame_ack==0 increments overrun_cnt, saturating at 255.
  - frame_ack==1: frame_ready drops the next cycle and state returns to IDLE. A read_valid in the same cycle as ack is ignored and not counted as overrun.
  - The new frame begins at the next bin 0.
- Readback:
  - rd_en sampled in any state; rd_data/rd_valid appear 1 cycle later (synchronous RAM).
  - Data is defined only while frame_ready==1.
  - Readback has no effect on state.
- Held values:
  - peak_bin/peak_mag keep their values until the next completed frame.
  - seq_error and overrun_cnt clear only on reset.
- Reset mid-CAPTURE or mid-HOLD: immediate return to IDLE, frame_ready=0, partial frame lost.

Test Plan:
- Stream bins 0..511 consecutively; bin 37 = (re 1000, im -500), all others (10,10) -> frame_ready=1 one cycle after bin 511; peak_bin=37, peak_mag=1500; peak_valid is a single one-cycle pulse.
- Bin 5 and bin 9 both at mag 800, rest lower; plus bin 0 = 5000 and bin 300 = 9000 -> peak_bin=5, peak_mag=800 (DC and mirror excluded, tie goes to lowest).
- Bin with re=-131072, im=0 -> mag 131071; readback rd_addr=that bin returns {0,0x20000} one cycle after rd_en.
- Addresses 0,1,2,4 -> seq_error=1, frame_ready stays 0; a following clean 0..511 frame completes normally.
- Hold the frame; deliver 300 further valid bins with ack low -> overrun_cnt=255. Assert ack -> frame_ready=0 next cycle; the next 0..511 sequence recaptures.
- Assert reset low at bin 200 of a frame -> all outputs 0 immediately; after release a full frame is captured correctly.

Source files
------------

// File: rtl/fft_frame_capture.sv
// Captures one FFT frame of bins into a synchronous buffer, tracks the peak
// |re|+|im| bin over the non-DC lower half-spectrum, and holds the frame for a reader.
module fft_frame_capture #(
    parameter int LOG_DEPTH = 9,
    parameter int DW        = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DW-1:0]        data_real_in,
    input  logic [DW-1:0]        data_imag_in,
    input  logic [LOG_DEPTH-1:0] bin_addr_in,
    input  logic                 read_valid,
    input  logic [LOG_DEPTH-1:0] rd_addr,
    input  logic                 rd_en,
    output logic [2*DW-1:0]      rd_data,
    output logic                 rd_valid,
    output logic                 frame_ready,
    input  logic                 frame_ack,
    output logic [LOG_DEPTH-1:0] peak_bin,
    output logic [DW:0]          peak_mag,
    output logic                 peak_valid,
    output logic                 seq_error,
    output logic [7:0]           overrun_cnt
);

    localparam int N = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH-1:0] LAST_BIN = LOG_DEPTH'(N - 1);
    localparam logic [LOG_DEPTH-1:0] HALF_BIN = LOG_DEPTH'(N / 2);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [LOG_DEPTH-1:0]   exp_q, exp_d;
    logic [DW:0]            max_q, max_d;
    logic [LOG_DEPTH-1:0]   maxbin_q, maxbin_d;
    logic [LOG_DEPTH-1:0]   peak_bin_q, peak_bin_d;
    logic [DW:0]            peak_mag_q, peak_mag_d;
    logic                   peak_valid_q, peak_valid_d;
    logic                   frame_ready_q, frame_ready_d;
    logic                   seq_err_q, seq_err_d;
    logic [7:0]             ovr_q, ovr_d;
    logic                   rd_valid_q;
    logic [2*DW-1:0]        rd_raw_q;
    logic                   wr_en;
    logic [DW:0]            mag;
    logic                   in_half;

    logic [2*DW-1:0] mem [N];

    // The most negative value has no positive twin, so it clips to full scale.
    function automatic logic [DW-2:0] abs_sat(input logic [DW-1:0] x);
        logic [DW-1:0] neg;
        neg = -x;
        if (x == {1'b1, {(DW-1){1'b0}}})
            abs_sat = '1;
        else if (x[DW-1])
            abs_sat = neg[DW-2:0];
        else
            abs_sat = x[DW-2:0];
    endfunction

    assign mag     = {2'b00, abs_sat(data_real_in)} + {2'b00, abs_sat(data_imag_in)};
    assign in_half = (bin_addr_in != '0) && (bin_addr_in < HALF_BIN);

    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        max_d         = max_q;
        maxbin_d      = maxbin_q;
        peak_bin_d    = peak_bin_q;
        peak_mag_d    = peak_mag_q;
        peak_valid_d  = 1'b0;
        frame_ready_d = frame_ready_q;
        seq_err_d     = seq_err_q;
        ovr_d         = ovr_q;
        wr_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_valid && bin_addr_in == '0) begin
                    wr_en    = 1'b1;
                    exp_d    = LOG_DEPTH'(1);
                    max_d    = '0;
                    maxbin_d = LOG_DEPTH'(1);
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (read_valid) begin
                    if (bin_addr_in == exp_q) begin
                        wr_en = 1'b1;
                        exp_d = exp_q + 1'b1;
                        if (in_half && mag > max_q) begin
                            max_d    = mag;
                            maxbin_d = bin_addr_in;
                        end
                        if (bin_addr_in == LAST_BIN) begin
                            state_d       = HOLD;
                            frame_ready_d = 1'b1;
                            peak_valid_d  = 1'b1;
                            peak_bin_d    = maxbin_d;
                            peak_mag_d    = max_d;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    frame_ready_d = 1'b0;
                    state_d       = IDLE;
                end else if (read_valid && ovr_q != '1) begin
                    ovr_d = ovr_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            exp_q         <= '0;
            max_q         <= '0;
            maxbin_q      <= '0;
            peak_bin_q    <= '0;
            peak_mag_q    <= '0;
            peak_valid_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            seq_err_q     <= 1'b0;
            ovr_q         <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            max_q         <= max_d;
            maxbin_q      <= maxbin_d;
            peak_bin_q    <= peak_bin_d;
            peak_mag_q    <= peak_mag_d;
            peak_valid_q  <= peak_valid_d;
            frame_ready_q <= frame_ready_d;
            seq_err_q     <= seq_err_d;
            ovr_q         <= ovr_d;
            rd_valid_q    <= rd_en;
        end
    end

    // Buffer and its read register stay reset-free so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[bin_addr_in] <= {data_imag_in, data_real_in};
        if (rd_en)
            rd_raw_q <= mem[rd_addr];
    end

    assign rd_data     = rd_valid_q ? rd_raw_q : '0;
    assign rd_valid    = rd_valid_q;
    assign frame_ready = frame_ready_q;
    assign peak_bin    = peak_bin_q;
    assign peak_mag    = peak_mag_q;
    assign peak_valid  = peak_valid_q;
    assign seq_error   = seq_err_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_fft_frame_capture.sv
// Bench for fft_frame_capture: table-driven single-peak frames, hand-written
// corner sequences and randomized frames checked against a frame-array model.
module tb_fft_frame_capture;

    localparam int LD = 9;
    localparam int DW = 18;
    localparam int N  = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_real_in, data_imag_in;
    logic [LD-1:0] bin_addr_in, rd_addr;
    logic          read_valid, rd_en, frame_ack;
    logic [2*DW-1:0] rd_data;
    logic          rd_valid, frame_ready, peak_valid, seq_error;
    logic [LD-1:0] peak_bin;
    logic [DW:0]   peak_mag;
    logic [7:0]    overrun_cnt;

    always #5 clk = ~clk;

    fft_frame_capture #(.LOG_DEPTH(LD), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .data_real_in(data_real_in), .data_imag_in(data_imag_in),
        .bin_addr_in(bin_addr_in), .read_valid(read_valid),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_ready(frame_ready), .frame_ack(frame_ack),
        .peak_bin(peak_bin), .peak_mag(peak_mag), .peak_valid(peak_valid),
        .seq_error(seq_error), .overrun_cnt(overrun_cnt)
    );

    int vectors = 0;
    int miscompares = 0;
    int fr_re[N];
    int fr_im[N];
    int exp_ovr = 0;
    int exp_seq = 0;

    typedef struct {
        int bin;
        int re;
        int im;
        int exp_bin;
        int exp_mag;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int absat(input int x);
        if (x == -131072) return 131071;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int magof(input int b);
        return absat(fr_re[b]) + absat(fr_im[b]);
    endfunction

    // Largest magnitude over bins 1..N/2-1, then the first bin that reaches it.
    task automatic ref_peak(output int pb, output int pm);
        pm = 0;
        for (int b = 1; b < N / 2; b++)
            if (magof(b) > pm) pm = magof(b);
        pb = 1;
        for (int b = N / 2 - 1; b >= 1; b--)
            if (magof(b) == pm) pb = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bin(input int a, input int re, input int im);
        bin_addr_in  = a[LD-1:0];
        data_real_in = re[DW-1:0];
        data_imag_in = im[DW-1:0];
        read_valid   = 1'b1;
        tick();
        read_valid   = 1'b0;
    endtask

    task automatic fill_bg(input int re, input int im);
        for (int b = 0; b < N; b++) begin
            fr_re[b] = re;
            fr_im[b] = im;
        end
    endtask

    function automatic int rnd_comp();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return -131072;
        if (r < 4) return int'($urandom_range(0, 262143)) - 131072;
        return int'($urandom_range(0, 2000)) - 1000;
    endfunction

    task automatic fill_random();
        for (int b = 0; b < N; b++) begin
            fr_re[b] = rnd_comp();
            fr_im[b] = rnd_comp();
        end
    endtask

    task automatic check_done(input string tag);
        int pb, pm;
        ref_peak(pb, pm);
        chk({tag, "_ready"}, frame_ready, 1);
        chk({tag, "_pvalid"}, peak_valid, 1);
        chk({tag, "_pbin"}, peak_bin, pb);
        chk({tag, "_pmag"}, peak_mag, pm);
        chk({tag, "_seqerr"}, seq_error, exp_seq);
        chk({tag, "_ovr"}, overrun_cnt, exp_ovr);
        tick();
        chk({tag, "_pvalid_pulse"}, peak_valid, 0);
        chk({tag, "_ready_held"}, frame_ready, 1);
    endtask

    task automatic run_frame(input string tag, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 3));
            if (i == N - 1) begin
                chk({tag, "_ready_early"}, frame_ready, 0);
                chk({tag, "_pvalid_early"}, peak_valid, 0);
            end
            send_bin(i, fr_re[i], fr_im[i]);
        end
        check_done(tag);
    endtask

    task automatic readback(input int a);
        logic [DW-1:0] r, m;
        r = fr_re[a][DW-1:0];
        m = fr_im[a][DW-1:0];
        rd_addr = a[LD-1:0];
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, {m, r});
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ack_ready_drop", frame_ready, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, frame_ready, 0);
        chk({tag, "_pbin"}, peak_bin, 0);
        chk({tag, "_pmag"}, peak_mag, 0);
        chk({tag, "_pvalid"}, peak_valid, 0);
        chk({tag, "_seqerr"}, seq_error, 0);
        chk({tag, "_ovr"}, overrun_cnt, 0);
        chk({tag, "_rdvalid"}, rd_valid, 0);
        chk({tag, "_rddata"}, rd_data, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pb_hold;
        tbl[0] = '{37, 1000, -500, 37, 1500};
        tbl[1] = '{100, -131072, 0, 100, 131071};
        tbl[2] = '{255, -131072, -131072, 255, 262142};
        tbl[3] = '{0, 5000, 5000, 1, 20};
        tbl[4] = '{256, 9000, 0, 1, 20};
        tbl[5] = '{1, 131071, 131071, 1, 262142};
        tbl[6] = '{200, 5, 5, 1, 20};
        tbl[7] = '{128, 0, -21, 128, 21};

        reset = 1'b0; read_valid = 1'b0; rd_en = 1'b0; frame_ack = 1'b0;
        data_real_in = '0; data_imag_in = '0; bin_addr_in = '0; rd_addr = '0;
        #12;
        check_all_zero("por");
        @(negedge clk) reset = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) begin
            fill_bg(10, 10);
            fr_re[tbl[k].bin] = tbl[k].re;
            fr_im[tbl[k].bin] = tbl[k].im;
            run_frame("tbl", k[0]);
            chk("tbl_exp_bin", peak_bin, tbl[k].exp_bin);
            chk("tbl_exp_mag", peak_mag, tbl[k].exp_mag);
            readback(tbl[k].bin);
            if (tbl[k].bin == 100) chk("min_rd_data", rd_data, 36'h000020000);
            ack_frame();
        end

        // Tie between bins 5 and 9; larger DC and mirror-half values excluded.
        for (int b = 0; b < N; b++) begin
            fr_re[b] = $urandom_range(0, 100);
            fr_im[b] = -int'($urandom_range(0, 100));
        end
        fr_re[5] = 800;    fr_im[5] = 0;
        fr_re[9] = -300;   fr_im[9] = -500;
        fr_re[0] = 5000;   fr_im[0] = 0;
        fr_re[300] = 9000; fr_im[300] = 0;
        run_frame("tie", 1'b1);
        chk("tie_bin", peak_bin, 5);
        chk("tie_mag", peak_mag, 800);
        readback(0);
        readback(300);
        ack_frame();
        chk("peak_held_idle", peak_bin, 5);

        fill_bg(0, 0);
        fr_re[0] = 7; fr_im[400] = 50;
        run_frame("zero", 1'b0);
        chk("zero_bin", peak_bin, 1);
        chk("zero_mag", peak_mag, 0);
        ack_frame();

        // Overrun while holding, plus an ack-cycle bin that must be ignored.
        fill_random();
        run_frame("ovr1", 1'b1);
        for (int i = 0; i < 10; i++) send_bin(i, 1, 1);
        exp_ovr = 10;
        chk("ovr_10", overrun_cnt, exp_ovr);
        frame_ack = 1'b1; read_valid = 1'b1; bin_addr_in = '0;
        tick();
        frame_ack = 1'b0; read_valid = 1'b0;
        chk("ack_valid_ready", frame_ready, 0);
        chk("ack_valid_ovr", overrun_cnt, exp_ovr);
        send_bin(5, 3, 3);
        chk("ack_bin0_not_started", seq_error, 0);
        fill_random();
        run_frame("ovr2", 1'b0);
        for (int i = 0; i < 300; i++) begin
            send_bin(i % N, 77, 77);
            if (i == 99) chk("ovr_110", overrun_cnt, 110);
        end
        exp_ovr = 255;
        chk("ovr_sat", overrun_cnt, exp_ovr);
        readback(37);
        readback(511);
        ack_frame();

        // Sequence errors: skipped address, then a restart-looking bin 0.
        send_bin(0, 1, 1); send_bin(1, 1, 1); send_bin(2, 1, 1); send_bin(4, 1, 1);
        exp_seq = 1;
        chk("seq_err_set", seq_error, 1);
        chk("seq_err_ready", frame_ready, 0);
        send_bin(0, 1, 1); send_bin(1, 1, 1); send_bin(2, 1, 1); send_bin(0, 1, 1);
        for (int i = 1; i < N; i++) send_bin(i, 2, 2);
        chk("seq_no_restart", frame_ready, 0);
        fill_random();
        run_frame("seq_clean", 1'b1);
        readback(128);
        ack_frame();

        // Asynchronous reset in the middle of a frame.
        fill_random();
        for (int i = 0; i < 200; i++) send_bin(i, fr_re[i], fr_im[i]);
        #2 reset = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk) reset = 1'b1;
        exp_seq = 0; exp_ovr = 0;
        tick();
        for (int i = 200; i < 260; i++) send_bin(i, 4, 4);
        chk("rst_no_resume", frame_ready, 0);
        run_frame("post_rst", 1'b1);
        readback(199);
        ack_frame();

        for (int f = 0; f < 3; f++) begin
            int k;
            fill_random();
            run_frame("rand", 1'b1);
            for (int r = 0; r < 6; r++) readback($urandom_range(0, N - 1));
            k = $urandom_range(0, 5);
            for (int i = 0; i < k; i++) send_bin($urandom_range(0, N - 1), 9, 9);
            exp_ovr = (exp_ovr + k > 255) ? 255 : exp_ovr + k;
            chk("rand_ovr", overrun_cnt, exp_ovr);
            pb_hold = peak_bin;
            ack_frame();
            idle_cycles($urandom_range(0, 4));
        end
        chk("rand_seqerr", seq_error, exp_seq);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
